// File: rtl/multicycle_control_pkg.sv
// multicycle_ctrl_pkg: shared types and constants for the multi-cycle controller.
// FSM state encoding, ALU operation codes, default opcode encodings and a
// small helper that picks the EXEC-phase ALU operation from the opcode class.
package multicycle_ctrl_pkg;

  // FSM states; codes 5-7 are unused and recover to FETCH
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // ALU operation select driven on alu_op
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  // Default opcode field width and encodings
  localparam int         DEF_OPC_W   = 6;
  localparam logic [5:0] DEF_OP_R    = 6'b000000;
  localparam logic [5:0] DEF_OP_J    = 6'b000010;
  localparam logic [5:0] DEF_OP_BEQ  = 6'b000100;
  localparam logic [5:0] DEF_OP_ADDI = 6'b001000;
  localparam logic [5:0] DEF_OP_ANDI = 6'b001100;
  localparam logic [5:0] DEF_OP_LW   = 6'b100011;
  localparam logic [5:0] DEF_OP_SW   = 6'b101011;

  // ALU operation used during EXEC (and held through MEM) for a legal class
  function automatic logic [1:0] exec_alu_op(input logic is_r, input logic is_andi);
    logic [1:0] op;
    if (is_r) begin
      op = ALU_FUNCT;
    end else if (is_andi) begin
      op = ALU_AND;
    end else begin
      op = ALU_ADD;
    end
    return op;
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// opcode_class: combinational decode of the latched opcode into one-hot
// class flags. Exactly one flag is set for any opcode value; anything that
// matches none of the configured encodings is flagged illegal.
module opcode_class
  import multicycle_ctrl_pkg::*;
#(
  parameter int               OPC_W   = DEF_OPC_W,
  parameter logic [OPC_W-1:0] OP_R    = DEF_OP_R,
  parameter logic [OPC_W-1:0] OP_J    = DEF_OP_J,
  parameter logic [OPC_W-1:0] OP_BEQ  = DEF_OP_BEQ,
  parameter logic [OPC_W-1:0] OP_ADDI = DEF_OP_ADDI,
  parameter logic [OPC_W-1:0] OP_ANDI = DEF_OP_ANDI,
  parameter logic [OPC_W-1:0] OP_LW   = DEF_OP_LW,
  parameter logic [OPC_W-1:0] OP_SW   = DEF_OP_SW
) (
  input  logic [OPC_W-1:0] opc,
  output logic             is_r,
  output logic             is_j,
  output logic             is_beq,
  output logic             is_addi,
  output logic             is_andi,
  output logic             is_lw,
  output logic             is_sw,
  output logic             is_illegal
);

  // Priority chain keeps the flags one-hot even if two encodings collide
  always_comb begin
    is_r       = 1'b0;
    is_j       = 1'b0;
    is_beq     = 1'b0;
    is_addi    = 1'b0;
    is_andi    = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_illegal = 1'b0;
    if (opc == OP_R) begin
      is_r = 1'b1;
    end else if (opc == OP_J) begin
      is_j = 1'b1;
    end else if (opc == OP_BEQ) begin
      is_beq = 1'b1;
    end else if (opc == OP_ADDI) begin
      is_addi = 1'b1;
    end else if (opc == OP_ANDI) begin
      is_andi = 1'b1;
    end else if (opc == OP_LW) begin
      is_lw = 1'b1;
    end else if (opc == OP_SW) begin
      is_sw = 1'b1;
    end else begin
      is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing each instruction through
// FETCH/DECODE/EXEC/MEM/WB and issuing datapath enables for a multi-cycle
// datapath with one shared ALU and one shared memory.
// Optional build macro MULTICYCLE_CTRL_MEM_HS_EN: MEM waits for mem_ready=1
// before leaving; without it mem_ready is ignored and MEM lasts one cycle.
module multicycle_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int               OPC_W   = DEF_OPC_W,
  parameter logic [OPC_W-1:0] OP_R    = DEF_OP_R,
  parameter logic [OPC_W-1:0] OP_J    = DEF_OP_J,
  parameter logic [OPC_W-1:0] OP_BEQ  = DEF_OP_BEQ,
  parameter logic [OPC_W-1:0] OP_ADDI = DEF_OP_ADDI,
  parameter logic [OPC_W-1:0] OP_ANDI = DEF_OP_ANDI,
  parameter logic [OPC_W-1:0] OP_LW   = DEF_OP_LW,
  parameter logic [OPC_W-1:0] OP_SW   = DEF_OP_SW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_dest,
  output logic             jump,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_to_reg,
  output logic             mem_write,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal_op
);

  state_t           state_r;
  state_t           state_next_s;
  logic [OPC_W-1:0] opc_r;        // opcode captured on the FETCH->DECODE edge
  logic             mem_done_s;   // MEM may complete this cycle

  logic is_r_s, is_j_s, is_beq_s, is_addi_s;
  logic is_andi_s, is_lw_s, is_sw_s, is_illegal_s;

`ifdef MULTICYCLE_CTRL_MEM_HS_EN
  assign mem_done_s = mem_ready;
`else
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = mem_ready;
  assign mem_done_s         = 1'b1;
`endif

  opcode_class #(
    .OPC_W   (OPC_W),
    .OP_R    (OP_R),
    .OP_J    (OP_J),
    .OP_BEQ  (OP_BEQ),
    .OP_ADDI (OP_ADDI),
    .OP_ANDI (OP_ANDI),
    .OP_LW   (OP_LW),
    .OP_SW   (OP_SW)
  ) u_opcode_class (
    .opc        (opc_r),
    .is_r       (is_r_s),
    .is_j       (is_j_s),
    .is_beq     (is_beq_s),
    .is_addi    (is_addi_s),
    .is_andi    (is_andi_s),
    .is_lw      (is_lw_s),
    .is_sw      (is_sw_s),
    .is_illegal (is_illegal_s)
  );

  // State register; reset forces FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Opcode latch: only the FETCH cycle samples the opcode input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opc_r <= '0;
    end else if (state_r == ST_FETCH) begin
      opc_r <= opcode;
    end else begin
      opc_r <= opc_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = ST_FETCH;
    case (state_r)
      ST_FETCH: begin
        state_next_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_r_s || is_addi_s || is_andi_s || is_lw_s || is_sw_s) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_FETCH;   // J, BEQ and illegal finish here
        end
      end
      ST_EXEC: begin
        if (is_lw_s || is_sw_s) begin
          state_next_s = ST_MEM;
        end else begin
          state_next_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (!mem_done_s) begin
          state_next_s = ST_MEM;
        end else if (is_lw_s) begin
          state_next_s = ST_WB;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_WB: begin
        state_next_s = ST_FETCH;
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // Moore output decode from the registered state and latched opcode class
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_dest   = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_r)
      ST_FETCH: begin
        pc_write = 1'b1;
        ir_write = 1'b1;
      end
      ST_DECODE: begin
        if (is_j_s) begin
          jump       = 1'b1;
          instr_done = 1'b1;
        end else if (is_beq_s) begin
          branch     = 1'b1;
          alu_op     = ALU_SUB;
          instr_done = 1'b1;
        end else if (is_illegal_s) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end else begin
          instr_done = 1'b0;
        end
      end
      ST_EXEC: begin
        alu_op  = exec_alu_op(is_r_s, is_andi_s);
        alu_src = ~is_r_s;
      end
      ST_MEM: begin
        // ALU controls stay at their EXEC values so the address is stable
        alu_op  = exec_alu_op(is_r_s, is_andi_s);
        alu_src = ~is_r_s;
        if (is_lw_s) begin
          mem_read = 1'b1;
        end else if (is_sw_s) begin
          mem_write  = 1'b1;
          instr_done = mem_done_s;
        end else begin
          mem_read = 1'b0;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        reg_dest   = is_r_s;
        mem_to_reg = is_lw_s;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign state = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A per-instruction reference
// model lists the expected state and output word for every cycle of an
// instruction, derived from the instruction latency/enable rules.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_dest, jump, branch, mem_read;
  logic       mem_to_reg, mem_write, alu_src, reg_write, instr_done, illegal_op;
  logic [1:0] alu_op;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_dest   (reg_dest),
    .jump       (jump),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  localparam logic [5:0] C_R = 6'b000000, C_J = 6'b000010, C_BEQ = 6'b000100;
  localparam logic [5:0] C_ADDI = 6'b001000, C_ANDI = 6'b001100;
  localparam logic [5:0] C_LW = 6'b100011, C_SW = 6'b101011;

  // Output word layout: {pc_write, ir_write, reg_dest, jump, branch, mem_read,
  //  mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0], instr_done, illegal_op}
  localparam logic [13:0] PC = 14'h2000, IR = 14'h1000, RD = 14'h0800, JP = 14'h0400;
  localparam logic [13:0] BR = 14'h0200, MR = 14'h0100, M2R = 14'h0080, MW = 14'h0040;
  localparam logic [13:0] AS = 14'h0020, RW = 14'h0010, A_SUB = 14'h0004;
  localparam logic [13:0] A_FN = 14'h0008, A_AND = 14'h000C, DN = 14'h0002, IL = 14'h0001;

  logic [13:0] obs;
  assign obs = {pc_write, ir_write, reg_dest, jump, branch, mem_read, mem_to_reg,
                mem_write, alu_src, reg_write, alu_op, instr_done, illegal_op};

  typedef struct {
    logic [2:0]  st;
    logic [13:0] o;
    logic        rdy;
  } step_t;

  step_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic add(input logic [2:0] st, input logic [13:0] o, input logic rdy);
    step_t s;
    s.st = st; s.o = o; s.rdy = rdy;
    q.push_back(s);
  endtask

  // Reference model: expected cycle list for one instruction
  task automatic build(input logic [5:0] opc, input int stall_in);
    int stall;
    logic [13:0] ex;
    bit legal_multi;
    stall = stall_in;
`ifndef MULTICYCLE_CTRL_MEM_HS_EN
    stall = 0;
`endif
    q.delete();
    legal_multi = (opc == C_R) || (opc == C_ADDI) || (opc == C_ANDI) ||
                  (opc == C_LW) || (opc == C_SW);
    add(3'd0, PC | IR, 1'($urandom));
    if (opc == C_J) begin
      add(3'd1, JP | DN, 1'($urandom));
    end else if (opc == C_BEQ) begin
      add(3'd1, BR | A_SUB | DN, 1'($urandom));
    end else if (!legal_multi) begin
      add(3'd1, IL | DN, 1'($urandom));
    end else begin
      add(3'd1, 14'h0000, 1'($urandom));
      ex = (opc == C_R) ? A_FN : ((opc == C_ANDI) ? (A_AND | AS) : AS);
      add(3'd2, ex, 1'($urandom));
      if (opc == C_LW || opc == C_SW) begin
        for (int i = 0; i <= stall; i++) begin
          logic rdy;
`ifdef MULTICYCLE_CTRL_MEM_HS_EN
          rdy = (i == stall);
`else
          rdy = 1'($urandom);
`endif
          if (opc == C_LW) add(3'd3, ex | MR, rdy);
          else add(3'd3, ex | MW | ((i == stall) ? DN : 14'h0000), rdy);
        end
        if (opc == C_LW) add(3'd4, RW | M2R | DN, 1'($urandom));
      end else begin
        add(3'd4, RW | DN | ((opc == C_R) ? RD : 14'h0000), 1'($urandom));
      end
    end
  endtask

  // Run one instruction from a negedge with the DUT in FETCH; optionally
  // assert reset in the middle of the first MEM cycle
  task automatic run(input logic [5:0] opc, input int stall, input bit abort);
    build(opc, stall);
    for (int i = 0; i < q.size(); i++) begin
      opcode    = (i == 0) ? opc : 6'($urandom);
      mem_ready = q[i].rdy;
      #1;
      check($sformatf("op%02h_cyc%0d_state", opc, i + 1), 16'(state), 16'(q[i].st));
      check($sformatf("op%02h_cyc%0d_outs", opc, i + 1), 16'(obs), 16'(q[i].o));
      if (abort && q[i].st == 3'd3) begin
        #2 reset = 1'b1;
        #1;
        check("midreset_state", 16'(state), 16'd0);
        check("midreset_outs", 16'(obs), 16'(PC | IR));
        @(negedge clk);
        check("midreset_hold_outs", 16'(obs), 16'(PC | IR));
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] legal [7];
    logic [5:0] op;
    legal[0] = C_R;  legal[1] = C_J;  legal[2] = C_BEQ; legal[3] = C_ADDI;
    legal[4] = C_ANDI; legal[5] = C_LW; legal[6] = C_SW;

    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    #3;
    check("reset_state", 16'(state), 16'd0);
    check("reset_outs", 16'(obs), 16'(PC | IR));
    @(negedge clk);
    check("reset_after_edge_state", 16'(state), 16'd0);
    reset = 1'b0;

    run(C_LW, 3, 1'b0);
    run(C_SW, 0, 1'b0);
    run(C_BEQ, 0, 1'b0);
    run(C_R, 0, 1'b0);
    run(C_ANDI, 0, 1'b0);
    run(6'b111111, 0, 1'b0);
    run(C_SW, 1, 1'b1);
    run(C_ADDI, 0, 1'b0);
    run(C_J, 0, 1'b0);
    run(C_SW, 2, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(3, 0) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(6, 0)];
      run(op, int'($urandom_range(3, 0)), 1'b0);
    end

    opcode = 6'($urandom);
    #1;
    check("final_fetch_state", 16'(state), 16'd0);
    check("final_fetch_outs", 16'(obs), 16'(PC | IR));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
